mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Arbiter sharing one single-port memory between instruction fetch and load/store
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   IReq, IAddr, IFlush           fetch request, fetch address, fetch redirect
//   IRdata, IValid                returned instruction word and its one-cycle valid pulse
//   DReq, DWe, DAddr, DWdata      data request, store select, data address, store data
//   DRdata, DValid                load result and its one-cycle completion pulse
//   MemReq, MemWe, MemAddr,
//   MemWdata                      registered request towards the shared memory
//   MemRdata, MemAck              memory read data and completion pulse
//   StallF                        fetch stall: IReq and not IValid (combinational)

module mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IReq,
  input  logic [DATA_WIDTH-1:0] IAddr,
  input  logic                  IFlush,
  output logic [31:0]           IRdata,
  output logic                  IValid,
  input  logic                  DReq,
  input  logic                  DWe,
  input  logic [DATA_WIDTH-1:0] DAddr,
  input  logic [DATA_WIDTH-1:0] DWdata,
  output logic [DATA_WIDTH-1:0] DRdata,
  output logic                  DValid,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [DATA_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWdata,
  input  logic [DATA_WIDTH-1:0] MemRdata,
  input  logic                  MemAck,
  output logic                  StallF
);

  localparam int CW = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY
  } state_t;

  state_t        state;
  logic [CW-1:0] burst_cnt;
  logic          fetch_killed;  // a redirect arrived while this fetch was in flight
  logic          data_first;
  logic [31:0]   fetch_word;

  // Data wins unless the fetch side has already waited out a full data burst.
  assign data_first = DReq && (!IReq || (burst_cnt < BURST_MAX));
  assign fetch_word = 32'(MemRdata);
  assign StallF     = IReq && !IValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      burst_cnt    <= '0;
      fetch_killed <= 1'b0;
      MemReq       <= 1'b0;
      MemWe        <= 1'b0;
      MemAddr      <= '0;
      MemWdata     <= '0;
      IRdata       <= '0;
      IValid       <= 1'b0;
      DRdata       <= '0;
      DValid       <= 1'b0;
    end else begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      case (state)
        IDLE: begin
          if (data_first) begin
            state    <= DBUSY;
            MemReq   <= 1'b1;
            MemWe    <= DWe;
            MemAddr  <= DAddr;
            MemWdata <= DWdata;
            // Only data grants that make a waiting fetch wait longer count.
            if (IReq) begin
              if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
            end else begin
              burst_cnt <= '0;
            end
          end else if (IReq) begin
            state        <= IBUSY;
            MemReq       <= 1'b1;
            MemWe        <= 1'b0;
            MemAddr      <= IAddr;
            burst_cnt    <= '0;
            fetch_killed <= 1'b0;
          end
        end
        IBUSY: begin
          if (MemAck) begin
            state  <= IDLE;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            // A flush seen earlier or on the ack edge itself discards the word.
            if (!fetch_killed && !IFlush) begin
              IValid <= 1'b1;
              IRdata <= fetch_word;
            end
          end else if (IFlush) begin
            fetch_killed <= 1'b1;
          end
        end
        DBUSY: begin
          if (MemAck) begin
            state  <= IDLE;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            DValid <= 1'b1;
            if (!MemWe) DRdata <= MemRdata;
          end
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
          MemWe  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter with a reference model and memory responder

module tb_mem_arbiter;

  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          IReq, IFlush, DReq, DWe;
  logic [DW-1:0] IAddr, DAddr, DWdata;
  logic [31:0]   IRdata;
  logic          IValid;
  logic [DW-1:0] DRdata;
  logic          DValid;
  logic          MemReq, MemWe;
  logic [DW-1:0] MemAddr, MemWdata;
  logic [DW-1:0] MemRdata = '0;
  logic          MemAck = 1'b0;
  logic          StallF;

  int total  = 0;
  int passed = 0;

  int wait_states = 0;
  bit spurious    = 1'b0;
  logic [31:0] mem [logic [31:0]];

  mem_arbiter #(.DATA_WIDTH(DW), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .IReq(IReq), .IAddr(IAddr), .IFlush(IFlush), .IRdata(IRdata), .IValid(IValid),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DRdata(DRdata), .DValid(DValid),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck), .StallF(StallF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  // Memory: acks after wait_states extra cycles of MemReq; can also fire a stray ack while idle.
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    MemAck = 1'b0;
    if (MemReq === 1'b1) begin
      if (wcnt >= wait_states) begin
        MemAck   = 1'b1;
        MemRdata = mem_rd(MemAddr);
        if (MemWe === 1'b1) mem[MemAddr] = MemWdata;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      if (spurious) begin
        MemAck   = 1'b1;
        MemRdata = 32'h0BAD_0BAD;
      end
    end
  end

  // Reference model: one outstanding access, owned by either fetch or data.
  logic        m_busy, m_fetch, m_we, m_dropped, m_ivalid, m_dvalid;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  int          m_streak;
  logic        m_take_data;

  assign m_take_data = DReq && !(IReq && (m_streak >= MAXB));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_fetch <= 1'b0; m_we <= 1'b0; m_dropped <= 1'b0;
      m_ivalid <= 1'b0; m_dvalid <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_irdata <= '0; m_drdata <= '0; m_streak <= 0;
    end else begin
      m_ivalid <= 1'b0;
      m_dvalid <= 1'b0;
      if (m_busy) begin
        if (MemAck) begin
          m_busy <= 1'b0;
          m_we   <= 1'b0;
          if (m_fetch) begin
            if (!m_dropped && !IFlush) begin
              m_ivalid <= 1'b1;
              m_irdata <= MemRdata;
            end
          end else begin
            m_dvalid <= 1'b1;
            if (!m_we) m_drdata <= MemRdata;
          end
        end else if (m_fetch && IFlush) begin
          m_dropped <= 1'b1;
        end
      end else if (m_take_data) begin
        m_busy <= 1'b1; m_fetch <= 1'b0;
        m_addr <= DAddr; m_we <= DWe; m_wdata <= DWdata;
        m_streak <= IReq ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 0;
      end else if (IReq) begin
        m_busy <= 1'b1; m_fetch <= 1'b1; m_dropped <= 1'b0;
        m_addr <= IAddr; m_we <= 1'b0; m_streak <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_MemReq",   MemReq,   m_busy);
    check("cmp_MemWe",    MemWe,    m_we);
    check("cmp_MemAddr",  MemAddr,  m_addr);
    check("cmp_MemWdata", MemWdata, m_wdata);
    check("cmp_IValid",   IValid,   m_ivalid);
    check("cmp_IRdata",   IRdata,   m_irdata);
    check("cmp_DValid",   DValid,   m_dvalid);
    check("cmp_DRdata",   DRdata,   m_drdata);
    check("cmp_StallF",   StallF,   IReq && !m_ivalid);
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_ivalid(input string name, input int limit);
    int n = 0;
    while (IValid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check({name, "_ivalid_seen"}, IValid, 1'b1);
  endtask

  task automatic run_burst(output int dcount, output bit seen);
    dcount = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DValid === 1'b1) dcount++;
      if (IValid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dcount, hold;
    bit  seen, iv, dv, mr;
    IReq = 0; IFlush = 0; DReq = 0; DWe = 0; IAddr = '0; DAddr = '0; DWdata = '0;
    mem[32'h40]  = 32'h00500093;
    mem[32'h44]  = 32'h00A00113;
    mem[32'h48]  = 32'h00000013;
    mem[32'h4C]  = 32'h00100073;
    mem[32'h80]  = 32'h11111111;
    mem[32'h90]  = 32'h22222222;
    mem[32'hA0]  = 32'h33333333;
    mem[32'h100] = 32'h12345678;
    mem[32'h104] = 32'hCAFE0001;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_MemReq", MemReq, 1'b0);
    check("rst_MemWe", MemWe, 1'b0);
    check("rst_MemAddr", MemAddr, 32'h0);
    check("rst_MemWdata", MemWdata, 32'h0);
    check("rst_IRdata", IRdata, 32'h0);
    check("rst_DRdata", DRdata, 32'h0);
    check("rst_IValid", IValid, 1'b0);
    check("rst_DValid", DValid, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    // Fetch only, zero wait states.
    IReq = 1; IAddr = 32'h40;
    tick();
    check("t1_MemReq", MemReq, 1'b1);
    check("t1_MemAddr", MemAddr, 32'h40);
    check("t1_MemWe", MemWe, 1'b0);
    check("t1_StallF", StallF, 1'b1);
    tick();
    check("t1_IValid", IValid, 1'b1);
    check("t1_IRdata", IRdata, 32'h00500093);
    IReq = 0;
    tick();

    // Simultaneous fetch and load: data first.
    IReq = 1; IAddr = 32'h44; DReq = 1; DWe = 0; DAddr = 32'h100;
    tick();
    check("t2_MemAddr_data", MemAddr, 32'h100);
    check("t2_MemWe", MemWe, 1'b0);
    tick();
    check("t2_DValid", DValid, 1'b1);
    check("t2_DRdata", DRdata, 32'h12345678);
    check("t2_IValid_early", IValid, 1'b0);
    DReq = 0;
    tick();
    check("t2_MemReq_fetch", MemReq, 1'b1);
    check("t2_MemAddr_fetch", MemAddr, 32'h44);
    tick();
    check("t2_IValid", IValid, 1'b1);
    check("t2_IRdata", IRdata, 32'h00A00113);
    IReq = 0;
    tick();

    // Starvation limit, twice in a row to show the counter restarting.
    IReq = 1; IAddr = 32'h48; DReq = 1; DWe = 0; DAddr = 32'h104;
    run_burst(dcount, seen);
    check("t3_fetch_seen_1", seen, 1'b1);
    check("t3_data_count_1", dcount, 4);
    check("t3_IRdata_1", IRdata, 32'h00000013);
    IAddr = 32'h4C;
    run_burst(dcount, seen);
    check("t3_fetch_seen_2", seen, 1'b1);
    check("t3_data_count_2", dcount, 4);
    check("t3_IRdata_2", IRdata, 32'h00100073);
    IReq = 0; DReq = 0;
    tick();

    // Store leaves DRdata alone.
    DReq = 1; DWe = 1; DAddr = 32'h200; DWdata = 32'hDEADBEEF;
    tick();
    check("t4_MemReq", MemReq, 1'b1);
    check("t4_MemWe", MemWe, 1'b1);
    check("t4_MemAddr", MemAddr, 32'h200);
    check("t4_MemWdata", MemWdata, 32'hDEADBEEF);
    tick();
    check("t4_DValid", DValid, 1'b1);
    check("t4_DRdata_kept", DRdata, 32'hCAFE0001);
    DReq = 0; DWe = 0;
    tick();
    check("t4_mem_written", mem_rd(32'h200), 32'hDEADBEEF);

    // Flush during a fetch with three wait states.
    wait_states = 3;
    IReq = 1; IAddr = 32'h80;
    tick();
    check("t5_MemAddr_old", MemAddr, 32'h80);
    IFlush = 1; IAddr = 32'h90;
    tick();
    IFlush = 0;
    hold = 2; iv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (IValid === 1'b1) iv = 1;
      if (MemReq === 1'b1) hold++;
      else break;
    end
    check("t5_MemReq_held", hold, 4);
    check("t5_no_IValid", iv, 1'b0);
    check("t5_IRdata_kept", IRdata, 32'h00100073);
    tick();
    check("t5_MemAddr_new", MemAddr, 32'h90);
    wait_ivalid("t5", 10);
    check("t5_IRdata_new", IRdata, 32'h22222222);
    IReq = 0;
    tick();

    // Flush coincident with the ack.
    wait_states = 1;
    IReq = 1; IAddr = 32'hA0;
    tick();
    tick();
    check("t6_ack_cycle", MemAck, 1'b1);
    IFlush = 1; IAddr = 32'h40;
    tick();
    IFlush = 0;
    check("t6_no_IValid", IValid, 1'b0);
    check("t6_IRdata_kept", IRdata, 32'h22222222);
    wait_ivalid("t6", 10);
    check("t6_IRdata_new", IRdata, 32'h00500093);
    IReq = 0;
    wait_states = 0;
    tick();

    // Stray ack while idle.
    spurious = 1;
    tick();
    spurious = 0;
    tick();
    check("t7_MemReq", MemReq, 1'b0);
    check("t7_DValid", DValid, 1'b0);
    check("t7_IValid", IValid, 1'b0);
    check("t7_DRdata", DRdata, 32'hCAFE0001);

    // Reset in the middle of a data access.
    wait_states = 2;
    DReq = 1; DWe = 0; DAddr = 32'h104;
    tick();
    check("t8_MemReq_before", MemReq, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t8_MemReq_in_reset", MemReq, 1'b0);
    check("t8_DRdata_in_reset", DRdata, 32'h0);
    DReq = 0;
    tick();
    tick();
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    dv = 0; mr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DValid === 1'b1) dv = 1;
      if (MemReq === 1'b1) mr = 1;
    end
    check("t8_no_DValid", dv, 1'b0);
    check("t8_idle", mr, 1'b0);
    wait_states = 0;
    DReq = 1; DAddr = 32'h100;
    tick();
    check("t8_regrant", MemAddr, 32'h100);
    tick();
    check("t8_DValid", DValid, 1'b1);
    check("t8_DRdata", DRdata, 32'h12345678);
    DReq = 0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
